// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration state encoding,
// default starvation limit and starvation counter width.
package pipeline_pkg;

  typedef enum logic {
    ARB_PIPE = 1'b0,
    ARB_DBG  = 1'b1
  } arb_state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned STARVE_W         = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating starvation counter: counts pipeline-won cycles while debug waits.
// Ports: clk, rst_n, inc_i, clr_i (clear wins), at_limit_o.
module starve_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  assign at_limit_o = (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:                 cnt_d = '0;
      inc_i && !at_limit_o:  cnt_d = cnt_q + 1'b1;
      default:               cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates DataMemo between MEM stage (priority, pass-through) and debug.
// Ports: clk/reset, p_* pipeline side, d_* debug side, Mem*/Address/Data_* memory side. Macro: DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import pipeline_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_rd,
  input  logic              p_wr,
  input  logic [DATA_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              stall_mem,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              MemRd,
  output logic              MemWr_final,
  output logic [DATA_W-1:0] Address,
  output logic [DATA_W-1:0] Data_in,
  input  logic [DATA_W-1:0] Data_out
);

  arb_state_e          state_q;
  arb_state_e          state_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                p_active;
  logic                hold_dbg;
  logic                cnt_inc;
  logic                cnt_clr;
  logic                at_limit;

  assign p_active = p_rd | p_wr;
  assign p_rdata  = Data_out;
  assign d_rvalid = rvalid_q;
  assign d_rdata  = rdata_q;

`ifdef DMEM_ARB_LOCK_EN
  assign hold_dbg = d_req & d_lock;
`else
  logic unused_lock;
  assign unused_lock = d_lock;
  assign hold_dbg    = 1'b0;
`endif

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (reset),
    .inc_i      (cnt_inc),
    .clr_i      (cnt_clr),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d     = state_q;
    MemRd       = 1'b0;
    MemWr_final = 1'b0;
    Address     = p_addr;
    Data_in     = p_wdata;
    d_gnt       = 1'b0;
    stall_mem   = 1'b0;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    unique case (state_q)
      ARB_PIPE: begin
        // store wins when both strobes are up
        MemRd       = p_rd & ~p_wr;
        MemWr_final = p_wr;
        cnt_inc     = p_active & d_req;
        cnt_clr     = ~d_req;
        if (d_req && (!p_active || at_limit))
          state_d = ARB_DBG;
      end
      ARB_DBG: begin
        Address     = d_addr;
        Data_in     = d_wdata;
        MemRd       = d_req & ~d_we;
        MemWr_final = d_req & d_we;
        d_gnt       = d_req;
        stall_mem   = p_active;
        if (!hold_dbg) begin
          state_d = ARB_PIPE;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = ARB_PIPE;
    endcase
    // no strobes may escape while reset is held, even between edges
    if (!reset) begin
      MemRd       = 1'b0;
      MemWr_final = 1'b0;
      d_gnt       = 1'b0;
      stall_mem   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_PIPE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= d_gnt & ~d_we;
      if (d_gnt && !d_we)
        rdata_q <= Data_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan plus random traffic
// against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int LIM = 4;
`ifdef DMEM_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        p_rd, p_wr;
  logic [31:0] p_addr, p_wdata, p_rdata;
  logic        stall_mem;
  logic        d_req, d_we, d_lock;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_gnt, d_rvalid;
  logic        MemRd, MemWr_final;
  logic [31:0] Address, Data_in, Data_out;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(LIM), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdata(p_rdata),
    .stall_mem(stall_mem),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .MemRd(MemRd), .MemWr_final(MemWr_final),
    .Address(Address), .Data_in(Data_in),
    .Data_out(Data_out)
  );

  // DataMemo stand-in
  logic [31:0] mem [0:63];
  logic        clr_mem;
  assign Data_out = mem[Address[5:0]];
  always @(posedge clk) begin
    if (clr_mem)
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (MemWr_final)
      mem[Address[5:0]] <= Data_in;
  end

  int errors = 0;
  int checks = 0;

  // reference model
  logic [31:0] ref_mem [0:63];
  bit          m_dbg;
  int          m_cnt;
  bit          m_rv;
  logic [31:0] m_rd;
  int          wait_cnt;
  bit          e_rd, e_wr, e_gnt, e_stall;
  logic [31:0] e_addr, e_din;
  bit          obs_gnt, obs_stall, obs_rv, obs_mrd, obs_mwr;
  logic [31:0] obs_prdata, obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit pa;
    pa = p_rd | p_wr;
    if (!reset) begin
      m_dbg = 0; m_cnt = 0; m_rv = 0; m_rd = '0;
      e_rd = 0; e_wr = 0; e_gnt = 0; e_stall = 0;
      e_addr = p_addr; e_din = p_wdata;
    end else if (!m_dbg) begin
      e_rd = p_rd && !p_wr; e_wr = p_wr;
      e_gnt = 0; e_stall = 0;
      e_addr = p_addr; e_din = p_wdata;
    end else begin
      e_rd = d_req && !d_we; e_wr = d_req && d_we;
      e_gnt = d_req; e_stall = pa;
      e_addr = d_addr; e_din = d_wdata;
    end
  endtask

  task automatic model_seq();
    bit pa;
    pa = p_rd | p_wr;
    if (!reset) begin
      m_dbg = 0; m_cnt = 0; m_rv = 0; m_rd = '0;
      return;
    end
    m_rv = e_gnt && !d_we;
    if (m_rv) m_rd = ref_mem[d_addr[5:0]];
    if (e_wr) ref_mem[e_addr[5:0]] = e_din;
    if (!m_dbg) begin
      m_dbg = d_req && (!pa || m_cnt == LIM);
      if (!d_req) m_cnt = 0;
      else if (pa && m_cnt < LIM) m_cnt = m_cnt + 1;
    end else if (!(LOCK && d_req && d_lock)) begin
      m_dbg = 0;
      m_cnt = 0;
    end
  endtask

  // one clock cycle: settle, check, then advance through the edge
  task automatic tick();
    #2;
    model_comb();
    obs_gnt = d_gnt; obs_stall = stall_mem; obs_rv = d_rvalid;
    obs_mrd = MemRd; obs_mwr = MemWr_final;
    obs_prdata = p_rdata; obs_rdata = d_rdata;
    chk("MemRd", 32'(MemRd), 32'(e_rd));
    chk("MemWr_final", 32'(MemWr_final), 32'(e_wr));
    chk("d_gnt", 32'(d_gnt), 32'(e_gnt));
    chk("stall_mem", 32'(stall_mem), 32'(e_stall));
    chk("d_rvalid", 32'(d_rvalid), 32'(m_rv));
    chk("d_rdata", d_rdata, m_rd);
    if (reset) begin
      chk("Address", Address, e_addr);
      if (e_wr) chk("Data_in", Data_in, e_din);
      if (!m_dbg && p_rd && !p_wr)
        chk("p_rdata", p_rdata, ref_mem[p_addr[5:0]]);
    end
    if (reset && d_req) begin
      if (e_gnt) begin
        chk("dbg_latency", 32'(wait_cnt <= LIM + 1), 32'd1);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    @(posedge clk);
    model_seq();
    #1;
  endtask

  initial begin
    int lat;
    int ngnt, nstall;
    reset = 1'b0; clr_mem = 1'b1;
    p_rd = 0; p_wr = 0; p_addr = '0; p_wdata = '0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    m_dbg = 0; m_cnt = 0; m_rv = 0; m_rd = '0; wait_cnt = 0;
    #1;
    chk("rst_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_rdata", d_rdata, 32'd0);
    chk("rst_memwr", 32'(MemWr_final), 32'd0);
    tick();
    tick();
    clr_mem = 1'b0;
    reset = 1'b1;

    // pipeline-only store then load
    p_wr = 1; p_addr = 32'd10; p_wdata = 32'hAAAA5555;
    tick();
    chk("pipe_st_stall", 32'(obs_stall), 32'd0);
    chk("pipe_st_gnt", 32'(obs_gnt), 32'd0);
    p_wr = 0; p_rd = 1;
    tick();
    chk("pipe_ld_data", obs_prdata, 32'hAAAA5555);
    chk("pipe_ld_stall", 32'(obs_stall), 32'd0);

    // idle pipeline debug read
    p_rd = 0;
    d_req = 1; d_we = 0; d_addr = 32'd10;
    tick();
    chk("idle_gnt0", 32'(obs_gnt), 32'd0);
    tick();
    chk("idle_gnt1", 32'(obs_gnt), 32'd1);
    d_req = 0;
    tick();
    chk("idle_rvalid", 32'(obs_rv), 32'd1);
    chk("idle_rdata", obs_rdata, 32'hAAAA5555);

    // starvation with continuous loads
    p_rd = 1; p_addr = 32'd10;
    d_req = 1; d_we = 0; d_addr = 32'd10;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_gnt) begin
        lat = i;
        chk("starve_stall", 32'(obs_stall), 32'd1);
        break;
      end
    end
    chk("starve_lat", 32'(lat), 32'(LIM + 1));
    d_req = 0;
    tick();
    chk("starve_after_stall", 32'(obs_stall), 32'd0);
    chk("starve_after_data", obs_prdata, 32'hAAAA5555);
    chk("starve_rvalid", 32'(obs_rv), 32'd1);

    // both strobes: store wins
    p_rd = 1; p_wr = 1; p_addr = 32'd20; p_wdata = 32'h12345678;
    tick();
    chk("both_memrd", 32'(obs_mrd), 32'd0);
    chk("both_memwr", 32'(obs_mwr), 32'd1);
    p_wr = 0;
    tick();
    chk("both_readback", obs_prdata, 32'h12345678);

    // lock
    p_rd = 1; p_addr = 32'd20;
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 32'd20;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_gnt) begin
        lat = i;
        break;
      end
    end
    chk("lock_first_gnt", 32'(lat >= 0), 32'd1);
    ngnt = 1; nstall = 1;
    tick();
    ngnt += int'(obs_gnt); nstall += int'(obs_stall);
    d_lock = 0;
    tick();
    ngnt += int'(obs_gnt); nstall += int'(obs_stall);
    chk("lock_gnts", 32'(ngnt), LOCK ? 32'd3 : 32'd1);
    chk("lock_stalls", 32'(nstall), LOCK ? 32'd3 : 32'd1);
    d_req = 0; p_rd = 0;
    tick();
    tick();

    // reset during a debug write slot
    d_req = 1; d_we = 1; d_lock = 1;
    d_addr = 32'd10; d_wdata = 32'hDEAD0000;
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_memwr", 32'(MemWr_final), 32'd0);
    chk("rstmid_gnt", 32'(d_gnt), 32'd0);
    chk("rstmid_rvalid", 32'(d_rvalid), 32'd0);
    tick();
    d_req = 0; d_lock = 0; d_we = 0;
    reset = 1'b1;
    tick();
    p_rd = 1; p_addr = 32'd10;
    tick();
    chk("rstmid_mem", obs_prdata, 32'hAAAA5555);
    chk("rstmid_stall", 32'(obs_stall), 32'd0);
    p_rd = 0;
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!((p_rd || p_wr) && e_stall)) begin
        p_rd    = ($urandom % 2) == 0;
        p_wr    = ($urandom % 4) == 0;
        p_addr  = 32'($urandom_range(0, 15));
        p_wdata = $urandom;
      end
      if (!(d_req && !e_gnt)) begin
        d_req   = ($urandom % 3) == 0;
        d_we    = ($urandom % 2) == 0;
        d_lock  = ($urandom % 4) == 0;
        d_addr  = 32'($urandom_range(0, 15));
        d_wdata = $urandom;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`DataMemo`) between the pipeline MEM stage and a debug/loader port. The pipeline has priority and sees a zero-latency pass-through when it owns the memory. Debug accesses win a slot when the pipeline is idle, or after a bounded starvation interval, in which case the MEM stage is stalled. The block sits between the EX/MEM buffer and `DataMemo`, and feeds `stall_mem` into the hazard/stall logic.

## Interface
- `STARVE_LIMIT`, default 4: consecutive pipeline-won cycles, with debug pending, before debug is forced in; legal range 1..15.
- `DATA_W`, default 32: data and address width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `p_rd` in 1: pipeline load request.
- `p_wr` in 1: pipeline store request.
- `p_addr` in 32: pipeline address.
- `p_wdata` in 32: pipeline store data.
- `p_rdata` out 32: load data to the pipeline, combinational from `Data_out`.
- `stall_mem` out 1: pipeline request not served this cycle; the pipeline must hold its MEM inputs stable.
- `d_req` in 1: debug request, held until `d_gnt`.
- `d_we` in 1: debug write (1) or read (0).
- `d_lock` in 1: keep debug ownership for the next cycle.
- `d_addr` in 32: debug address.
- `d_wdata` in 32: debug write data.
- `d_gnt` out 1: debug access performed this cycle.
- `d_rvalid` out 1: one-cycle pulse, `d_rdata` valid.
- `d_rdata` out 32: registered debug read data.
- `MemRd` out 1: memory read enable.
- `MemWr_final` out 1: memory write enable.
- `Address` out 32: memory address.
- `Data_in` out 32: memory write data.
- `Data_out` in 32: memory read data.

## Operation
- `p_active` = `p_rd | p_wr`. If both are asserted, the request is a store: `MemRd` = 0 and `MemWr_final` = 1.
- FSM has two states, ARB_PIPE and ARB_DBG.
- **ARB_PIPE** (reset state):
  - Memory is driven from the `p_*` inputs.
  - `d_gnt` = 0 and `stall_mem` = 0.
  - Exit to ARB_DBG at the edge when `d_req && (!p_active || starve_cnt == STARVE_LIMIT)`.
- **ARB_DBG**:
  - Memory is driven from the `d_*` inputs.
  - `MemRd` = `d_req & ~d_we`; `MemWr_final` = `d_req & d_we`.
  - `d_gnt` = `d_req`; `stall_mem` = `p_active`.
  - Stay in ARB_DBG at the edge if `d_req && d_lock`; otherwise return to ARB_PIPE.
- **Starvation counter** `starve_cnt`, width 4:
  - In ARB_PIPE, increments when `p_active && d_req`, saturating at `STARVE_LIMIT`.
  - Cleared on ARB_DBG→ARB_PIPE.
  - Cleared when `d_req` = 0 in ARB_PIPE.
- **Debug read response**: on an edge ending a cycle with `d_gnt && !d_we`, `d_rdata` <= `Data_out` and `d_rvalid` <= 1. Otherwise `d_rvalid` <= 0 and `d_rdata` holds its value.
- **`d_req` dropped in ARB_DBG**: no memory access is made, `d_gnt` = 0, and the FSM returns to ARB_PIPE.
- **Reset asserted** (`reset` = 0), immediately, regardless of clock:
  - State = ARB_PIPE, `starve_cnt` = 0.
  - `d_rvalid` = 0, `d_rdata` = 0.
  - `MemRd` = 0 and `MemWr_final` = 0, forced while reset is low.
  - `d_gnt` = 0, `stall_mem` = 0.
- **Reset mid-lock**: ownership is lost; debug must re-request.

## Timing
- Pipeline latency is 0 cycles: loads return combinationally in the same cycle, and stores commit at the next rising edge.
- Debug grant comes no earlier than 1 cycle after `d_req` rises (registered arbitration). It is bounded by `STARVE_LIMIT`+1 cycles while the pipeline is busy.
- Debug read data arrives 1 cycle after `d_gnt`, marked by the `d_rvalid` pulse.
- Without `d_lock`, the worst-case pipeline stall is 1 cycle per debug access.
- `stall_mem` is combinational from state and `p_active`; no multicycle paths.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: `d_lock` behaves as above, and consecutive debug cycles stall the pipeline indefinitely while locked.
- Undefined: `d_lock` is ignored, and ARB_DBG always lasts exactly one cycle before returning to ARB_PIPE.

## Structure
- Package `pipeline_pkg` holds:
  - The state encoding, ARB_PIPE = 1'b0 and ARB_DBG = 1'b1.
  - The default `STARVE_LIMIT`.
  - The `starve_cnt` width constant.
- One sub-module, `starve_counter`: a saturating counter with inc/clear/limit compare, exposing `at_limit`.
- The top level holds the FSM, the memory-side muxes and the `d_rdata` register.

## Test plan
- **Pipeline-only traffic**: store `32'hAAAA5555` to address 10, then load from address 10. Expect `p_rdata` = `AAAA5555`, `stall_mem` = 0 throughout, `d_gnt` = 0.
- **Idle pipeline**: `d_req` with a read of address 10. Expect `d_gnt` 1 cycle later, then `d_rvalid` pulse with `d_rdata` = `AAAA5555`.
- **Continuous `p_rd` with `d_req` held, `STARVE_LIMIT` = 4**: expect the debug grant on cycle 5. `stall_mem` = 1 for that one cycle; the pipeline load completes the following cycle with unchanged data.
- **`p_rd` and `p_wr` both asserted**, address 20, data `12345678`: expect `MemRd` = 0, `MemWr_final` = 1, and a later read returns `12345678`.
- **`d_lock` held 3 cycles with `DMEM_ARB_LOCK_EN` defined**: expect 3 consecutive `d_gnt` and `stall_mem` = 1 for 3 cycles. With the macro undefined, expect a single `d_gnt`, with debug re-arbitrated afterwards.
- **`reset` pulled low during ARB_DBG with `d_we` = 1**: expect `MemWr_final` = 0 immediately, `d_rvalid` = 0, and the state back in ARB_PIPE. Address 10 still reads `AAAA5555` after release.
